// File: rtl/rcc_rtc_pkg.sv
// Shared encodings for the RTC kernel clock source sequencer.
package rcc_rtc_pkg;

   localparam logic [1:0] RTCSEL_NONE = 2'b00;
   localparam logic [1:0] RTCSEL_LSE  = 2'b01;
   localparam logic [1:0] RTCSEL_LSI  = 2'b10;
   localparam logic [1:0] RTCSEL_HSE  = 2'b11;

   localparam logic [1:0] RSP_OK   = 2'b00;
   localparam logic [1:0] RSP_WP   = 2'b01;
   localparam logic [1:0] RSP_NRDY = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GATE_OFF,
      ST_SWITCH,
      ST_ENABLE
   } rtc_state_e;

   function automatic logic src_rdy(input logic [1:0] sel, input logic lse,
                                    input logic lsi, input logic hse);
      logic r;
      r = 1'b0;
      case (sel)
         RTCSEL_LSE: r = lse;
         RTCSEL_LSI: r = lsi;
         RTCSEL_HSE: r = hse;
         default:    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rcc_rtc_src_seq.sv
// RTC kernel clock source sequencer: write-once rtcsel, gate-off-before-switch,
// and automatic LSE->LSI fallback on clock-security failure.
module rcc_rtc_src_seq
   import rcc_rtc_pkg::*;
#(
   parameter int unsigned OFF_CYC    = 4,
   parameter int unsigned SETTLE_CYC = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bdrst,
   input  logic       req_valid,
   input  logic [1:0] req_sel,
   input  logic       req_en,
   output logic       req_ready,
   input  logic       lse_rdy,
   input  logic       lsi_rdy,
   input  logic       hse_rdy,
   input  logic       lsecss_fail,
   output logic [1:0] rtcsel,
   output logic       rtcen,
   output logic       busy,
   output logic       rsp_valid,
   output logic [1:0] rsp_err,
   output logic       css_fb
);

   localparam int unsigned MAX_CYC = (OFF_CYC > SETTLE_CYC) ? OFF_CYC : SETTLE_CYC;
   localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

   rtc_state_e    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    tgt_sel, tgt_sel_n;
   logic          tgt_en, tgt_en_n;
   logic          fb_seq, fb_seq_n;
   logic [1:0]    rtcsel_n, rsp_err_n;
   logic          rtcen_n, css_fb_n, rsp_valid_n;
   logic          fallback_cond;

   assign fallback_cond = (rtcsel == RTCSEL_LSE) & lsecss_fail & ~css_fb;
   assign req_ready     = (state == ST_IDLE) & ~bdrst & ~fallback_cond;
   assign busy          = (state != ST_IDLE);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      tgt_sel_n   = tgt_sel;
      tgt_en_n    = tgt_en;
      fb_seq_n    = fb_seq;
      rtcsel_n    = rtcsel;
      rtcen_n     = rtcen;
      css_fb_n    = css_fb;
      rsp_valid_n = 1'b0;
      rsp_err_n   = rsp_err;
      if (bdrst) begin
         state_n   = ST_IDLE;
         cnt_n     = '0;
         fb_seq_n  = 1'b0;
         rtcsel_n  = RTCSEL_NONE;
         rtcen_n   = 1'b0;
         css_fb_n  = 1'b0;
         rsp_err_n = RSP_OK;
      end else begin
         case (state)
            ST_IDLE: begin
               // Fallback keeps the current enable and ignores write protection.
               if (fallback_cond) begin
                  tgt_sel_n = RTCSEL_LSI;
                  tgt_en_n  = rtcen;
                  fb_seq_n  = 1'b1;
                  rtcen_n   = 1'b0;
                  cnt_n     = CW'(OFF_CYC - 1);
                  state_n   = ST_GATE_OFF;
               end else if (req_valid) begin
                  if (rtcsel != RTCSEL_NONE && req_sel != rtcsel) begin
                     rsp_valid_n = 1'b1;
                     rsp_err_n   = RSP_WP;
                  end else if (req_sel != RTCSEL_NONE &&
                               !src_rdy(req_sel, lse_rdy, lsi_rdy, hse_rdy)) begin
                     rsp_valid_n = 1'b1;
                     rsp_err_n   = RSP_NRDY;
                  end else if (req_sel == rtcsel) begin
                     rtcen_n     = req_en;
                     rsp_valid_n = 1'b1;
                     rsp_err_n   = RSP_OK;
                  end else begin
                     tgt_sel_n = req_sel;
                     tgt_en_n  = req_en;
                     fb_seq_n  = 1'b0;
                     rtcen_n   = 1'b0;
                     cnt_n     = CW'(OFF_CYC - 1);
                     state_n   = ST_GATE_OFF;
                  end
               end
            end
            ST_GATE_OFF: begin
               if (cnt == '0) begin
                  rtcsel_n = tgt_sel;
                  cnt_n    = CW'(SETTLE_CYC - 1);
                  state_n  = ST_SWITCH;
               end else begin
                  cnt_n = cnt - 1'b1;
               end
            end
            ST_SWITCH: begin
               if (cnt == '0) begin
                  rtcen_n = tgt_en;
                  state_n = ST_ENABLE;
                  if (fb_seq) begin
                     css_fb_n = 1'b1;
                  end else begin
                     rsp_valid_n = 1'b1;
                     rsp_err_n   = RSP_OK;
                  end
               end else begin
                  cnt_n = cnt - 1'b1;
               end
            end
            ST_ENABLE: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         tgt_sel   <= RTCSEL_NONE;
         tgt_en    <= 1'b0;
         fb_seq    <= 1'b0;
         rtcsel    <= RTCSEL_NONE;
         rtcen     <= 1'b0;
         css_fb    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= RSP_OK;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         tgt_sel   <= tgt_sel_n;
         tgt_en    <= tgt_en_n;
         fb_seq    <= fb_seq_n;
         rtcsel    <= rtcsel_n;
         rtcen     <= rtcen_n;
         css_fb    <= css_fb_n;
         rsp_valid <= rsp_valid_n;
         rsp_err   <= rsp_err_n;
      end
   end

endmodule

// File: tb/tb_rcc_rtc_src_seq.sv
// Scoreboard bench for rcc_rtc_src_seq: directed scenarios plus randomized requests.
module tb_rcc_rtc_src_seq;

   localparam int unsigned OFF = 4;
   localparam int unsigned SET = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bdrst = 1'b0;
   logic       req_valid = 1'b0;
   logic [1:0] req_sel = 2'b00;
   logic       req_en = 1'b0;
   logic       req_ready;
   logic       lse_rdy = 1'b0, lsi_rdy = 1'b0, hse_rdy = 1'b0;
   logic       lsecss_fail = 1'b0;
   logic [1:0] rtcsel;
   logic       rtcen, busy, rsp_valid, css_fb;
   logic [1:0] rsp_err;

   rcc_rtc_src_seq #(.OFF_CYC(OFF), .SETTLE_CYC(SET)) dut (
      .clk(clk), .rst_n(rst_n), .bdrst(bdrst),
      .req_valid(req_valid), .req_sel(req_sel), .req_en(req_en), .req_ready(req_ready),
      .lse_rdy(lse_rdy), .lsi_rdy(lsi_rdy), .hse_rdy(hse_rdy), .lsecss_fail(lsecss_fail),
      .rtcsel(rtcsel), .rtcen(rtcen), .busy(busy),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .css_fb(css_fb)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  err;
      logic [1:0]  sel;
      logic        en;
      int unsigned cyc;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   // Reference state: what software should observe once a request has completed.
   logic [1:0] m_sel = 2'b00;
   logic       m_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic m_rdy(input logic [1:0] s);
      if (s == 2'b01) return lse_rdy;
      if (s == 2'b10) return lsi_rdy;
      if (s == 2'b11) return hse_rdy;
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("rsp_err", {30'd0, rsp_err}, {30'd0, mon_e.err});
            chk("rsp_sel", {30'd0, rtcsel}, {30'd0, mon_e.sel});
            chk("rsp_en",  {31'd0, rtcen},  {31'd0, mon_e.en});
            chk("rsp_cyc", cyc, mon_e.cyc);
         end
      end
   end

   task automatic send(input logic [1:0] s, input logic e, input bit expect_rsp);
      bit          ok;
      exp_t        x;
      int unsigned acc;
      req_sel   = s;
      req_en    = e;
      req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (req_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      acc = cyc;
      x.cyc = acc;
      if (m_sel != 2'b00 && s != m_sel) begin
         x.err = 2'b01;
      end else if (s != 2'b00 && !m_rdy(s)) begin
         x.err = 2'b10;
      end else if (s == m_sel) begin
         x.err = 2'b00;
         m_en  = e;
      end else begin
         x.err = 2'b00;
         m_sel = s;
         m_en  = e;
         x.cyc = acc + OFF + SET;
      end
      x.sel = m_sel;
      x.en  = m_en;
      if (expect_rsp) q.push_back(x);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (q.size() != 0 || busy); i++) @(negedge clk);
      chk("drain_q", q.size(), 32'd0);
   endtask

   task automatic do_bdrst();
      drain();
      @(negedge clk);
      bdrst = 1'b1;
      @(negedge clk);
      chk("bdrst_sel",   {30'd0, rtcsel}, 32'd0);
      chk("bdrst_en",    {31'd0, rtcen}, 32'd0);
      chk("bdrst_cssfb", {31'd0, css_fb}, 32'd0);
      chk("bdrst_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      bdrst = 1'b0;
      m_sel = 2'b00;
      m_en  = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned a, d, busy_n, low_n;
      bit          rdy_seen;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_sel",   {30'd0, rtcsel}, 32'd0);
      chk("rst_en",    {31'd0, rtcen}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_rspv",  {31'd0, rsp_valid}, 32'd0);
      chk("rst_err",   {30'd0, rsp_err}, 32'd0);
      chk("rst_cssfb", {31'd0, css_fb}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic switch with per-cycle timing window
      lse_rdy = 1'b1;
      send(2'b01, 1'b1, 1'b1);
      a = cyc;
      for (int k = 0; k <= int'(OFF + SET + 1); k++) begin
         @(negedge clk);
         d = cyc - a;
         chk("seq_busy",  {31'd0, busy},   {31'd0, d <= OFF + SET});
         chk("seq_sel",   {30'd0, rtcsel}, (d >= OFF) ? 32'd1 : 32'd0);
         chk("seq_en",    {31'd0, rtcen},  {31'd0, d >= OFF + SET});
      end
      drain();

      // Write protection, then enable-only update
      hse_rdy = 1'b1;
      send(2'b11, 1'b1, 1'b1);
      send(2'b01, 1'b0, 1'b1);
      drain();

      // Source not ready
      do_bdrst();
      hse_rdy = 1'b0;
      send(2'b11, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("nrdy_busy", {31'd0, busy}, 32'd0);
      end
      drain();

      // CSS fallback with a held request
      do_bdrst();
      lse_rdy = 1'b1;
      send(2'b01, 1'b1, 1'b1);
      drain();
      @(negedge clk);
      hse_rdy = 1'b1;
      lsecss_fail = 1'b1;
      req_sel = 2'b11;
      req_en = 1'b1;
      req_valid = 1'b1;
      #1;
      chk("fb_ready", {31'd0, req_ready}, 32'd0);
      busy_n = 0;
      low_n = 0;
      rdy_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy) begin
            busy_n++;
            if (!rtcen) low_n++;
            if (req_ready) rdy_seen = 1'b1;
         end else if (busy_n > 0) begin
            break;
         end
      end
      chk("fb_busy_cycles", busy_n, OFF + SET + 1);
      chk("fb_gate_cycles", low_n, OFF + SET);
      chk("fb_ready_held",  {31'd0, rdy_seen}, 32'd0);
      chk("fb_sel",   {30'd0, rtcsel}, 32'd2);
      chk("fb_en",    {31'd0, rtcen}, 32'd1);
      chk("fb_cssfb", {31'd0, css_fb}, 32'd1);
      m_sel = 2'b10;
      send(2'b11, 1'b1, 1'b1);
      lsecss_fail = 1'b0;
      drain();

      // bdrst during SWITCH
      do_bdrst();
      lse_rdy = 1'b1;
      send(2'b01, 1'b1, 1'b0);
      repeat (OFF + 2) @(negedge clk);
      chk("mid_sel",  {30'd0, rtcsel}, 32'd1);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      bdrst = 1'b1;
      @(negedge clk);
      chk("mid_rst_sel",  {30'd0, rtcsel}, 32'd0);
      chk("mid_rst_en",   {31'd0, rtcen}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_rspv", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      bdrst = 1'b0;
      m_sel = 2'b00;
      m_en = 1'b0;
      lsi_rdy = 1'b1;
      send(2'b10, 1'b1, 1'b1);
      drain();

      // Asynchronous reset mid GATE_OFF
      do_bdrst();
      send(2'b10, 1'b1, 1'b0);
      @(negedge clk);
      chk("pre_arst_busy", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy",  {31'd0, busy}, 32'd0);
      chk("arst_sel",   {30'd0, rtcsel}, 32'd0);
      chk("arst_en",    {31'd0, rtcen}, 32'd0);
      chk("arst_rspv",  {31'd0, rsp_valid}, 32'd0);
      chk("arst_cssfb", {31'd0, css_fb}, 32'd0);
      chk("arst_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      m_sel = 2'b00;
      m_en = 1'b0;

      // Randomized requests against the reference model
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 7) == 0) do_bdrst();
         lse_rdy = 1'($urandom_range(0, 1));
         lsi_rdy = 1'($urandom_range(0, 1));
         hse_rdy = 1'($urandom_range(0, 1));
         send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rcc_rtc_src_seq.md
# rcc_rtc_src_seq

Sequencer that owns the RTC kernel clock source controls (`rtcsel`, `rtcen`) feeding the VSW-domain RTC clock switch and gate. It accepts software source/enable requests through a valid/ready handshake. It enforces the backup-domain write-once rule on `rtcsel` and always gates the RTC clock off before changing the selection. On an LSE clock-security failure it automatically falls back to LSI. It runs on one control clock; all inputs are already synchronous to it.

## Interface
- `OFF_CYC`, default 4: cycles `rtcen` is held low before `rtcsel` changes (≥1).
- `SETTLE_CYC`, default 8: cycles after the `rtcsel` change before `rtcen` is restored (≥1).
- `clk` in 1: control clock.
- `rst_n` in 1: reset, asynchronous active-low.
- `bdrst` in 1: backup-domain reset, synchronous, level.
- `req_valid` in 1: request valid.
- `req_sel` in 2: requested source (00 none, 01 LSE, 10 LSI, 11 HSE).
- `req_en` in 1: requested `rtcen`.
- `req_ready` out 1: request accepted when high with `req_valid`.
- `lse_rdy`, `lsi_rdy`, `hse_rdy` in 1 each: source ready flags.
- `lsecss_fail` in 1: LSE CSS failure, level.
- `rtcsel` out 2: to the RTC clock switch.
- `rtcen` out 1: to the RTC kernel clock gate.
- `busy` out 1: sequence in progress.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_err` out 2: response code, valid with `rsp_valid` (00 ok, 01 write-protected, 10 source not ready).
- `css_fb` out 1: sticky, set when fallback has been performed.

## Operation
- **States:** IDLE, GATE_OFF, SWITCH, ENABLE.
- **Request acceptance:**
  - `req_ready` = IDLE & !`bdrst` & !fallback_cond.
  - fallback_cond = (`rtcsel`==01) & `lsecss_fail` & !`css_fb`.
- **Accept checks, in priority order:**
  1. `rtcsel`≠00 and `req_sel`≠`rtcsel` → reject, code 01.
  2. `req_sel`≠00 and the selected source's rdy=0 → reject, code 10.
  3. `req_sel`==`rtcsel` → enable-only update: `rtcen`←`req_en`, code 00, stay in IDLE.
  4. Otherwise latch the target (sel, en) and go to GATE_OFF.
- **Rejects** change no outputs.
- **GATE_OFF:**
  - `rtcen`=0.
  - Count `OFF_CYC` cycles, then go to SWITCH and drive `rtcsel`←target.
- **SWITCH:** count `SETTLE_CYC` cycles, then go to ENABLE.
- **ENABLE** (one cycle):
  - `rtcen`←target en.
  - Software sequences also emit `rsp_valid` with code 00.
  - Return to IDLE.
- **Fallback** (from IDLE when fallback_cond holds):
  - Target = 10 (LSI), en = current `rtcen`.
  - Runs the same GATE_OFF/SWITCH/ENABLE path.
  - `lsi_rdy` is not checked.
  - No `rsp_valid`.
  - `css_fb` is set in ENABLE.
  - Fallback overrides write protection.
- **Priority:** fallback beats a simultaneous request; the request stays pending (`req_ready`=0).
- **Write-once:** `rtcsel` becomes writable again only after `bdrst` returns it to 00.
- **`bdrst` high, in any state** (next edge):
  - state→IDLE.
  - `rtcsel`=00, `rtcen`=0, `css_fb`=0.
  - Counter cleared, any pending response is dropped.
  - Outputs hold those values while `bdrst` is high.
- **`busy`** = state≠IDLE.

## Timing
- **Reset values:** `rtcsel`=00, `rtcen`=0, `busy`=0, `rsp_valid`=0, `rsp_err`=00, `css_fb`=0, `req_ready`=1 (if `bdrst`=0).
- **Full sequence, accept at edge T:**
  - `rtcen`=0 and `busy`=1 from T+1.
  - `rtcsel`=target from T+1+`OFF_CYC`.
  - `rtcen`=target en and `rsp_valid` at T+1+`OFF_CYC`+`SETTLE_CYC`.
  - IDLE (and `req_ready`) one cycle later.
- **Reject or enable-only:** `rsp_valid` (and any `rtcen` change) at T+1.
- **Back-to-back requests:** allowed; `req_ready` stays 1.
- **Counter:** width $clog2(max(`OFF_CYC`,`SETTLE_CYC`))+1; loaded on state entry, decremented to zero, no wrap.
- **`lsecss_fail` deasserting mid-fallback** does not abort the fallback.
- **`lsecss_fail` during a 00→01 sequence:** the sequence completes, then fallback starts from the next IDLE cycle.

## Structure
- Package `rcc_rtc_pkg`:
  - RTCSEL_NONE/LSE/LSI/HSE encodings.
  - RSP_OK/RSP_WP/RSP_NRDY codes.
  - State enum type.
- Single module; counter and FSM inline. No sub-module is needed.

## Test plan
- **Basic switch:** reset, `lse_rdy`=1, request (01, en=1), `OFF_CYC`=4, `SETTLE_CYC`=8, accept at T → `rtcsel`=01 at T+5, `rtcen`=1 and `rsp_valid`/code 00 at T+13, `busy` high T+1..T+13.
- **Write protection:** `rtcsel`=01, request (11) with `hse_rdy`=1 → `rsp_err`=01 at T+1, `rtcsel`/`rtcen` unchanged. Request (01, en=0) → `rtcen`=0 at T+1, code 00.
- **Not ready:** from 00, request (11) with `hse_rdy`=0 → code 10 at T+1, `busy` never high.
- **CSS fallback:** `rtcsel`=01, `rtcen`=1, raise `lsecss_fail` with `req_valid` held → `req_ready`=0, `rtcen`=0 for `OFF_CYC`+`SETTLE_CYC` cycles, `rtcsel`=10, `rtcen`=1, `css_fb`=1, no `rsp_valid`. The held request is then accepted and rejected with code 01.
- **`bdrst` mid-sequence:** assert during SWITCH → next edge `rtcsel`=00, `rtcen`=0, `busy`=0, `css_fb`=0, no `rsp_valid`. After release, request (10) is accepted.
- **Async reset:** drop `rst_n` mid-GATE_OFF between clock edges → all outputs take reset values immediately.
